noc_apb_requester: RTL and testbench

Network interface (requester side) between a local APB master and its router's local port. Converts each APB transfer into a single-cycle request packet on the router's NI input and holds the APB access phase until the matching response packet arrives on the router's NI output, or until a timeout expires. One outstanding transfer at a time.

---
 rtl/noc_apb_requester.sv | 171 +++++++++++++++++
 tb/tb_noc_apb_requester.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_apb_requester.sv
// noc_apb_requester: requester-side network interface between a local APB
// master and the local port of its mesh router. Each APB transfer becomes one
// single-cycle request packet; the APB access phase is held until the matching
// response packet arrives or the wait timeout expires. One transfer in flight.
//
// Ports:
//   i_clk, i_srst        clock, synchronous active-high reset
//   i_psel .. i_pwdata   APB completer-side inputs
//   o_prdata, o_pready,
//   o_pslverr            APB completer-side outputs (o_pready is a 1-cycle pulse)
//   o_apbPacket          request packet to the router NI input ('0 when idle)
//   i_apbPacket          packet from the router NI output
//   o_drop               1-cycle pulse when a valid incoming packet is discarded
module noc_apb_requester #(
  parameter int unsigned ROUTER_ROW = 0,
  parameter int unsigned ROUTER_COL = 0,
  parameter int unsigned GRID_WIDTH = 4,
  parameter int unsigned TIMEOUT    = 64,
  localparam int unsigned APB_PACKET_WIDTH = 76
) (
  input  logic                        i_clk,
  input  logic                        i_srst,
  input  logic                        i_psel,
  input  logic                        i_penable,
  input  logic                        i_pwrite,
  input  logic [31:0]                 i_paddr,
  input  logic [31:0]                 i_pwdata,
  output logic [31:0]                 o_prdata,
  output logic                        o_pready,
  output logic                        o_pslverr,
  output logic [APB_PACKET_WIDTH-1:0] o_apbPacket,
  input  logic [APB_PACKET_WIDTH-1:0] i_apbPacket,
  output logic                        o_drop
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0] GRID_LIM = 3'(GRID_WIDTH);
  localparam logic [3:0] OWN_XY = {2'(ROUTER_ROW), 2'(ROUTER_COL)};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [APB_PACKET_WIDTH-1:0] pkt_q, pkt_d;
  logic                        pready_q, pready_d;
  logic                        pslverr_q, pslverr_d;
  logic [31:0]                 prdata_q, prdata_d;
  logic                        drop_q, drop_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [3:0]                  dst_q, dst_d;

  // Incoming packet field decode
  logic       in_valid;
  logic       in_resp;
  logic       in_err;
  logic [31:0] in_data;
  logic [3:0] in_src;
  logic [3:0] in_dst;
  logic       in_match;
  logic       accept;
  logic       setup;
  logic       dst_bad;

  assign in_valid = i_apbPacket[75];
  assign in_data  = i_apbPacket[74:43];
  assign in_err   = i_apbPacket[11];
  assign in_resp  = i_apbPacket[9];
  assign in_src   = i_apbPacket[7:4];
  assign in_dst   = i_apbPacket[3:0];

  // Address, pwrite and reserved fields of incoming packets carry no meaning here
  logic unused_in_fields;
  assign unused_in_fields = ^{i_apbPacket[42:12], i_apbPacket[10], i_apbPacket[8]};

  // Only a response from the node we asked, addressed to us, completes the transfer
  assign in_match = in_valid && in_resp && (in_dst == OWN_XY) && (in_src == dst_q);
  assign accept   = (state_q == ST_WAIT) && in_match;

  assign setup    = i_psel && !i_penable;
  assign dst_bad  = ({1'b0, i_paddr[31:30]} >= GRID_LIM) ||
                    ({1'b0, i_paddr[29:28]} >= GRID_LIM) ||
                    (i_paddr[31:28] == OWN_XY);

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    pkt_d     = '0;
    pready_d  = 1'b0;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    drop_d    = in_valid && !accept;
    cnt_d     = cnt_q;
    dst_d     = dst_q;

    unique case (state_q)
      ST_IDLE: begin
        if (setup) begin
          if (dst_bad) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
            state_d   = ST_DONE;
          end else begin
            dst_d   = i_paddr[31:28];
            pkt_d   = {1'b1, (i_pwrite ? i_pwdata : 32'h0), i_paddr[27:0], 3'b000,
                       1'b0, i_pwrite, 1'b0, 1'b0, OWN_XY, i_paddr[31:28]};
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (accept) begin
          prdata_d  = in_data;
          pslverr_d = in_err;
          pready_d  = 1'b1;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          prdata_d  = '0;
          pslverr_d = 1'b1;
          pready_d  = 1'b1;
          state_d   = ST_DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q   <= ST_IDLE;
      pkt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      drop_q    <= 1'b0;
      cnt_q     <= '0;
      dst_q     <= '0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      dst_q     <= dst_d;
    end
  end

  assign o_apbPacket = pkt_q;
  assign o_pready    = pready_q;
  assign o_pslverr   = pslverr_q;
  assign o_prdata    = prdata_q;
  assign o_drop      = drop_q;

endmodule

// File: tb/tb_noc_apb_requester.sv
// Testbench for noc_apb_requester: directed and randomized APB transfers
// against a transfer-level reference model that predicts, per cycle, the
// request packet, pready pulse, drop pulses and completion data.
module tb_noc_apb_requester;

  localparam int TO = 8;
  localparam int GW = 4;
  localparam logic [3:0] OWN = 4'h0;

  logic        i_clk = 1'b0;
  logic        i_srst;
  logic        i_psel;
  logic        i_penable;
  logic        i_pwrite;
  logic [31:0] i_paddr;
  logic [31:0] i_pwdata;
  logic [31:0] o_prdata;
  logic        o_pready;
  logic        o_pslverr;
  logic [75:0] o_apbPacket;
  logic [75:0] i_apbPacket;
  logic        o_drop;

  int n_tests = 0;
  int n_fail  = 0;

  noc_apb_requester #(
    .ROUTER_ROW(0),
    .ROUTER_COL(0),
    .GRID_WIDTH(GW),
    .TIMEOUT(TO)
  ) dut (
    .i_clk(i_clk),
    .i_srst(i_srst),
    .i_psel(i_psel),
    .i_penable(i_penable),
    .i_pwrite(i_pwrite),
    .i_paddr(i_paddr),
    .i_pwdata(i_pwdata),
    .o_prdata(o_prdata),
    .o_pready(o_pready),
    .o_pslverr(o_pslverr),
    .o_apbPacket(o_apbPacket),
    .i_apbPacket(i_apbPacket),
    .o_drop(o_drop)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [75:0] mk(input logic v, input logic [31:0] data,
                                     input logic [27:0] addr, input logic err,
                                     input logic wr, input logic rsp,
                                     input logic [3:0] src, input logic [3:0] dst);
    return {v, data, addr, 3'b000, err, wr, rsp, 1'b0, src, dst};
  endfunction

  // Random bits with the valid flag clear: must never be accepted or dropped
  function automatic logic [75:0] noise();
    logic [95:0] r;
    logic [75:0] p;
    r = {$urandom(), $urandom(), $urandom()};
    p = r[75:0];
    p[75] = 1'b0;
    return p;
  endfunction

  // Valid packets that must not complete a transfer to dst
  function automatic logic [75:0] junk(input logic [3:0] dst, input int kind);
    logic [3:0] nz;
    nz = 4'($urandom_range(1, 15));
    case (kind % 3)
      0:       return mk(1'b1, $urandom(), 28'($urandom()), 1'($urandom()), 1'($urandom()),
                         1'b1, dst ^ nz, OWN);
      1:       return mk(1'b1, $urandom(), 28'($urandom()), 1'b0, 1'($urandom()),
                         1'b0, dst, OWN);
      default: return mk(1'b1, $urandom(), 28'($urandom()), 1'($urandom()), 1'($urandom()),
                         1'b1, dst, OWN ^ nz);
    endcase
  endfunction

  // One APB transfer. d = WAIT-cycle index at which the response is driven
  // (negative: never); nj junk packets occupy WAIT cycles 0..nj-1.
  task automatic xfer(input int id, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input int d, input int nj,
                      input logic [31:0] rdata, input logic rerr, input logic glitch);
    logic [3:0]  dst;
    logic        bad;
    logic        prev_v;
    int          done_k;
    int          acc_c;
    logic [75:0] req;
    logic [75:0] rsp;
    logic [75:0] drv;
    dst    = addr[31:28];
    bad    = (dst == OWN) || (int'(dst[3:2]) >= GW) || (int'(dst[1:0]) >= GW);
    acc_c  = (!bad && d >= 0 && d <= TO - 1) ? 2 + d : -100;
    done_k = bad ? 1 : ((acc_c >= 0) ? acc_c + 1 : 2 + TO);
    req    = mk(1'b1, wr ? wdata : 32'h0, addr[27:0], 1'b0, wr, 1'b0, OWN, dst);
    rsp    = mk(1'b1, rdata, 28'($urandom()), rerr, 1'($urandom()), 1'b1, dst, OWN);
    drv    = noise();
    i_psel = 1'b1; i_penable = 1'b0; i_pwrite = wr; i_paddr = addr; i_pwdata = wdata;
    i_apbPacket = drv;
    for (int k = 1; k <= done_k + 1; k++) begin
      prev_v = drv[75] && (k - 1 != acc_c);
      @(posedge i_clk); #1;
      chk($sformatf("t%0d_pkt_k%0d", id, k), o_apbPacket, (k == 1 && !bad) ? req : 76'h0);
      chk($sformatf("t%0d_pready_k%0d", id, k), 76'(o_pready), 76'(k == done_k));
      chk($sformatf("t%0d_drop_k%0d", id, k), 76'(o_drop), 76'(prev_v));
      if (k == done_k) begin
        chk($sformatf("t%0d_prdata", id), 76'(o_prdata), 76'((acc_c >= 0) ? rdata : 32'h0));
        chk($sformatf("t%0d_pslverr", id), 76'(o_pslverr), 76'((acc_c >= 0) ? rerr : 1'b1));
        i_psel = 1'b0; i_penable = 1'b0;
      end else if (k < done_k) begin
        i_penable = 1'b1;
        if (glitch && k >= 2) i_psel = 1'b0;
      end
      if (!bad && d >= 0 && k - 2 == d) drv = rsp;
      else if (!bad && k >= 2 && k - 2 < nj) drv = junk(dst, k - 2);
      else drv = noise();
      i_apbPacket = drv;
    end
  endtask

  initial begin
    int d;
    int nj;
    int r;
    i_srst = 1'b1; i_psel = 1'b0; i_penable = 1'b0; i_pwrite = 1'b0;
    i_paddr = '0; i_pwdata = '0; i_apbPacket = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_pkt", o_apbPacket, 76'h0);
    chk("reset_pready", 76'(o_pready), 76'(0));
    chk("reset_pslverr", 76'(o_pslverr), 76'(0));
    chk("reset_prdata", 76'(o_prdata), 76'(0));
    chk("reset_drop", 76'(o_drop), 76'(0));
    i_srst = 1'b0;

    // Write to (1,1), response 5 cycles after SEND
    xfer(1, 32'h5000_0010, 1'b1, 32'hDEAD_BEEF, 4, 0, $urandom(), 1'b0, 1'b0);
    // Read from (2,3) with slave error in the response
    xfer(2, 32'hB000_0100, 1'b0, $urandom(), 2, 0, 32'h1234_5678, 1'b1, 1'b0);

    // Reset in the middle of WAIT, then a late response for the aborted transfer
    i_psel = 1'b1; i_penable = 1'b0; i_pwrite = 1'b0; i_paddr = 32'h6000_0044;
    i_apbPacket = noise();
    @(posedge i_clk); #1;
    chk("rst_req_valid", 76'(o_apbPacket[75]), 76'(1));
    i_penable = 1'b1; i_apbPacket = noise();
    repeat (3) begin @(posedge i_clk); #1; end
    i_srst = 1'b1;
    @(posedge i_clk); #1;
    i_srst = 1'b0; i_psel = 1'b0; i_penable = 1'b0;
    chk("rst_mid_pkt", o_apbPacket, 76'h0);
    chk("rst_mid_pready", 76'(o_pready), 76'(0));
    chk("rst_mid_pslverr", 76'(o_pslverr), 76'(0));
    chk("rst_mid_prdata", 76'(o_prdata), 76'(0));
    i_apbPacket = mk(1'b1, 32'hAAAA_5555, 28'h44, 1'b0, 1'b0, 1'b1, 4'h6, OWN);
    @(posedge i_clk); #1;
    chk("rst_late_drop", 76'(o_drop), 76'(1));
    chk("rst_late_pready", 76'(o_pready), 76'(0));
    i_apbPacket = noise();
    @(posedge i_clk); #1;
    chk("rst_after_pready", 76'(o_pready), 76'(0));
    chk("rst_after_drop", 76'(o_drop), 76'(0));

    // Normal transfer after reset
    xfer(3, 32'h6000_0044, 1'b1, 32'h0BAD_F00D, 1, 0, $urandom(), 1'b0, 1'b0);
    // Destination equals own coordinates: immediate error
    xfer(4, 32'h0000_0040, 1'b1, $urandom(), -1, 0, $urandom(), 1'b0, 1'b0);
    // Timeout, with a response arriving one cycle too late
    xfer(5, 32'h1000_0000, 1'b0, $urandom(), TO, 0, 32'h7777_7777, 1'b0, 1'b0);
    // Wrong source, request packet, then the correct response
    xfer(6, 32'h2000_0008, 1'b0, $urandom(), 2, 2, 32'hCAFE_F00D, 1'b0, 1'b0);
    // Response in the last possible WAIT cycle wins over the timeout
    xfer(7, 32'hF000_0ABC, 1'b0, $urandom(), TO - 1, 3, 32'h0F0F_1234, 1'b0, 1'b0);
    // Response in the first WAIT cycle, with psel dropped mid-transfer
    xfer(8, 32'h4000_0004, 1'b1, $urandom(), 0, 0, $urandom(), 1'b1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, TO + 1));
      d = (r == TO + 1) ? -1 : r;
      nj = (d >= 0) ? int'($urandom_range(0, (d < 3) ? d : 3)) : int'($urandom_range(0, 3));
      xfer(100 + i, $urandom(), 1'($urandom()), $urandom(), d, nj, $urandom(),
           1'($urandom()), 1'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
